breath_pwm_array: RTL and testbench

//  Multi-channel breathing-LED PWM engine driving a board LED bank. It has a shared timebase:

---
 rtl/breath_pkg.sv | 26 ++
 rtl/breath_timebase.sv | 90 +++++++++
 rtl/breath_pwm_array.sv | 74 +++++++
 tb/tb_breath_pwm_array.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breath_pkg.sv
// Shared constants for the breathing-LED PWM engine: channel modes,
// ramp direction encoding and a width helper for parameter-derived counters.
package breath_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'b00;
    localparam mode_t MODE_ON     = 2'b01;
    localparam mode_t MODE_BREATH = 2'b10;
    localparam mode_t MODE_ANTI   = 2'b11;

    typedef enum logic {
        DIR_RISE = 1'b0,
        DIR_FALL = 1'b1
    } dir_t;

    // Bits needed to hold 0..value-1; never less than 1 so a 2-entry range still gets a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((32'd1 << w) < value)
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/breath_timebase.sv
// Shared timebase: tick prescaler -> PWM frame counter -> brightness ramp ->
// rise/fall direction FSM. Produces the current PWM position, the brightness
// level seen by every channel, the frame boundary strobe and the half-breath pulse.
module breath_timebase
    import breath_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int PWM_STEPS = 1000,
    parameter int CW        = clog2(PWM_STEPS)
) (
    input  logic          system_clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] pwm_cnt,
    output logic [CW-1:0] level,
    output logic          frame_end,
    output dir_t          dir,
    output logic          half_pulse
);

    localparam int TW = clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] STEP_MAX = CW'(PWM_STEPS - 1);

    logic [TW-1:0] tick_cnt;
    logic [CW-1:0] ramp;
    logic          tick;
    logic          half_end;

    assign tick      = (tick_cnt == TICK_MAX);
    assign frame_end = tick && (pwm_cnt == STEP_MAX);
    assign half_end  = frame_end && (ramp == STEP_MAX);

    // Falling half mirrors the ramp so brightness is continuous across the turn.
    assign level = (dir == DIR_FALL) ? (STEP_MAX - ramp) : ramp;

    // Prescaler: one tick every TICK_DIV cycles.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (!en || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // PWM position within the frame, one step per tick.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else if (!en || frame_end)
            pwm_cnt <= '0;
        else if (tick)
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Brightness ramp, one step per frame; wraps at each half-breath.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)
            ramp <= '0;
        else if (!en || half_end)
            ramp <= '0;
        else if (frame_end)
            ramp <= ramp + 1'b1;
    end

    // Direction FSM: flips only at the end of a half-breath.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)
            dir <= DIR_RISE;
        else if (!en)
            dir <= DIR_RISE;
        else begin
            case (dir)
                DIR_RISE: if (half_end) dir <= DIR_FALL;
                DIR_FALL: if (half_end) dir <= DIR_RISE;
                default:  dir <= DIR_RISE;
            endcase
        end
    end

    // One-cycle strobe following each half-breath end.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)
            half_pulse <= 1'b0;
        else
            half_pulse <= en && half_end;
    end

endmodule

// File: rtl/breath_pwm_array.sv
// Multi-channel breathing-LED PWM engine. One shared timebase drives N_CH
// per-channel comparators; channel modes are shadowed and only take effect at
// frame boundaries so an output never glitches mid-frame.
module breath_pwm_array
    import breath_pkg::*;
#(
    parameter int N_CH      = 16,
    parameter int TICK_DIV  = 100,
    parameter int PWM_STEPS = 1000
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2*N_CH-1:0] mode_cfg,
    output logic [N_CH-1:0]   light,
    output logic              breath_dir,
    output logic              half_pulse
);

    localparam int CW = clog2(PWM_STEPS);
    localparam logic [CW-1:0] STEP_MAX = CW'(PWM_STEPS - 1);

    logic [CW-1:0]           pwm_cnt;
    logic [CW-1:0]           level;
    logic [CW-1:0]           anti_level;
    logic                    frame_end;
    dir_t                    dir;
    logic [N_CH-1:0][1:0]    mode_q;
    logic [N_CH-1:0]         light_d;

    breath_timebase #(
        .TICK_DIV  (TICK_DIV),
        .PWM_STEPS (PWM_STEPS),
        .CW        (CW)
    ) u_timebase (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .en         (en),
        .pwm_cnt    (pwm_cnt),
        .level      (level),
        .frame_end  (frame_end),
        .dir        (dir),
        .half_pulse (half_pulse)
    );

    assign breath_dir = (dir == DIR_FALL);
    assign anti_level = STEP_MAX - level;

    // Mode shadow: follows mode_cfg while idle, otherwise latches only at frame end.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= '0;
        else if (!en || frame_end)
            mode_q <= mode_cfg;
    end

    // Per-channel comparator; level = STEP_MAX still leaves one dark tick, only ON is 100%.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign light_d[i] = (mode_q[i] == MODE_ON)
                          | ((mode_q[i] == MODE_BREATH) & (pwm_cnt < level))
                          | ((mode_q[i] == MODE_ANTI)   & (pwm_cnt < anti_level));
    end

    // Output flops, forced dark while disabled.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)
            light <= '0;
        else if (!en)
            light <= '0;
        else
            light <= light_d;
    end

endmodule

// File: tb/tb_breath_pwm_array.sv
// Bench for breath_pwm_array. Expected outputs come from a closed-form model
// indexed by the number of enabled cycles since the last restart.
module tb_breath_pwm_array;

    localparam int N  = 4;
    localparam int TD = 2;
    localparam int PS = 4;
    localparam int FR = TD * PS;
    localparam int HB = TD * PS * PS;

    logic           system_clk = 1'b0;
    logic           rst_n      = 1'b0;
    logic           en         = 1'b0;
    logic [2*N-1:0] mode_cfg   = '0;
    logic [N-1:0]   light;
    logic           breath_dir;
    logic           half_pulse;

    logic [1:0]     mode_s = 2'b10;
    logic [0:0]     light_s;
    logic           dir_s;
    logic           hp_s;

    int checks = 0;
    int errors = 0;

    // model state
    int           k;
    logic [1:0]   mq [N];
    logic [N-1:0] e_light;
    logic         e_dir;
    logic         e_hp;

    always #5 system_clk = ~system_clk;

    breath_pwm_array #(.N_CH(N), .TICK_DIV(TD), .PWM_STEPS(PS)) dut (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode_cfg   (mode_cfg),
        .light      (light),
        .breath_dir (breath_dir),
        .half_pulse (half_pulse)
    );

    breath_pwm_array #(.N_CH(1), .TICK_DIV(5), .PWM_STEPS(10)) dut_s (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode_cfg   (mode_s),
        .light      (light_s),
        .breath_dir (dir_s),
        .half_pulse (hp_s)
    );

    task automatic model_reset();
        k = 0;
        for (int c = 0; c < N; c++) mq[c] = 2'b00;
        e_light = '0;
        e_dir   = 1'b0;
        e_hp    = 1'b0;
    endtask

    // Advance one clock; expectations follow from the cycle index k.
    task automatic step();
        logic [N-1:0] nl;
        logic         nhp;
        logic         ndir;
        logic [1:0]   nmq [N];
        int nk, pwm, rmp, lvl;
        bit fall;
        nl  = '0;
        nhp = 1'b0;
        if (!en) begin
            nk = 0;
            for (int c = 0; c < N; c++) nmq[c] = mode_cfg[2*c +: 2];
        end else begin
            pwm  = (k / TD) % PS;
            rmp  = (k / FR) % PS;
            fall = ((k / HB) % 2) == 1;
            lvl  = fall ? (PS - 1 - rmp) : rmp;
            for (int c = 0; c < N; c++) begin
                case (mq[c])
                    2'b01:   nl[c] = 1'b1;
                    2'b10:   nl[c] = (pwm < lvl);
                    2'b11:   nl[c] = (pwm < PS - 1 - lvl);
                    default: nl[c] = 1'b0;
                endcase
                nmq[c] = ((k % FR) == FR - 1) ? mode_cfg[2*c +: 2] : mq[c];
            end
            nhp = ((k % HB) == HB - 1);
            nk  = k + 1;
        end
        ndir = ((nk / HB) % 2) == 1;
        @(posedge system_clk);
        #1;
        k = nk;
        for (int c = 0; c < N; c++) mq[c] = nmq[c];
        e_light = nl;
        e_hp    = nhp;
        e_dir   = ndir;
    endtask

    task automatic restart();
        en = 1'b0;
        step();
        checks++;
        if (light !== '0 || breath_dir !== 1'b0 || half_pulse !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle light %b dir %b hp %b want 0 0 0", light, breath_dir, half_pulse);
        end
        en = 1'b1;
    endtask

    task automatic test_reset();
        en       = 1'b1;
        mode_cfg = 8'b10_10_10_10;
        repeat (3) @(posedge system_clk);
        #1;
        checks++;
        if (light !== '0) begin errors++; $display("FAIL reset_light got %b want 0", light); end
        checks++;
        if (breath_dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %b want 0", breath_dir); end
        checks++;
        if (half_pulse !== 1'b0) begin errors++; $display("FAIL reset_hp got %b want 0", half_pulse); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_full_breath();
        int duty [8];
        int exp_duty [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
        int first_hp = -1;
        int hp_n = 0;
        for (int f = 0; f < 8; f++) duty[f] = 0;
        for (int j = 1; j <= 64; j++) begin
            step();
            checks++;
            if (light !== e_light || breath_dir !== e_dir || half_pulse !== e_hp) begin
                errors++;
                $display("FAIL full_breath cyc %0d light %b/%b dir %b/%b hp %b/%b",
                         j, light, e_light, breath_dir, e_dir, half_pulse, e_hp);
            end
            if (light[0]) duty[(j-1)/8]++;
            if (half_pulse) begin
                hp_n++;
                if (first_hp < 0) first_hp = j;
                checks++;
                if (breath_dir !== 1'(hp_n % 2)) begin
                    errors++;
                    $display("FAIL dir_toggle pulse %0d dir %b want %0d", hp_n, breath_dir, hp_n % 2);
                end
            end
        end
        checks++;
        if (first_hp !== 32) begin errors++; $display("FAIL first_half_pulse got %0d want 32", first_hp); end
        for (int f = 0; f < 8; f++) begin
            checks++;
            if (duty[f] !== TD * exp_duty[f]) begin
                errors++;
                $display("FAIL frame_duty f%0d got %0d want %0d", f, duty[f], TD * exp_duty[f]);
            end
        end
    endtask

    task automatic test_anti();
        int d0 [8];
        int d1 [8];
        mode_cfg = {2'($urandom), 2'($urandom), 2'b11, 2'b10};
        restart();
        for (int f = 0; f < 8; f++) begin d0[f] = 0; d1[f] = 0; end
        for (int j = 1; j <= 64; j++) begin
            step();
            checks++;
            if (light !== e_light) begin
                errors++;
                $display("FAIL anti_model cyc %0d light %b want %b", j, light, e_light);
            end
            if (light[0]) d0[(j-1)/8]++;
            if (light[1]) d1[(j-1)/8]++;
        end
        for (int f = 0; f < 8; f++) begin
            checks++;
            if (d1[f] !== TD * (PS - 1) - d0[f]) begin
                errors++;
                $display("FAIL anti_duty f%0d ch1 %0d want %0d", f, d1[f], TD * (PS - 1) - d0[f]);
            end
        end
        checks++;
        if (d0[1] !== 2 || d1[1] !== 4) begin
            errors++;
            $display("FAIL anti_ramp1 ch0 %0d ch1 %0d want 2 4", d0[1], d1[1]);
        end
    endtask

    task automatic test_mode_change();
        mode_cfg = {2'($urandom), 2'b00, 2'($urandom), 2'($urandom)};
        restart();
        step();
        step();
        mode_cfg[5:4] = 2'b01;
        for (int j = 3; j <= 32; j++) begin
            step();
            checks++;
            if (light[2] !== (j >= 9) || light !== e_light) begin
                errors++;
                $display("FAIL mode_change cyc %0d light %b want %b ch2 want %0d", j, light, e_light, j >= 9);
            end
        end
    endtask

    task automatic test_en_drop();
        int first_hp = -1;
        mode_cfg = 8'($urandom);
        restart();
        repeat (50) step();
        en = 1'b0;
        step();
        checks++;
        if (light !== '0 || breath_dir !== 1'b0 || half_pulse !== 1'b0) begin
            errors++;
            $display("FAIL en_drop light %b dir %b hp %b want 0 0 0", light, breath_dir, half_pulse);
        end
        en = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step();
            checks++;
            if (light !== e_light || breath_dir !== e_dir || half_pulse !== e_hp) begin
                errors++;
                $display("FAIL en_replay cyc %0d light %b/%b dir %b/%b hp %b/%b",
                         j, light, e_light, breath_dir, e_dir, half_pulse, e_hp);
            end
            if (half_pulse && first_hp < 0) first_hp = j;
        end
        checks++;
        if (first_hp !== 32) begin errors++; $display("FAIL en_replay_hp got %0d want 32", first_hp); end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 300; j++) begin
            mode_cfg = 8'($urandom);
            en = ($urandom_range(0, 39) != 0);
            step();
            checks++;
            if (light !== e_light || breath_dir !== e_dir || half_pulse !== e_hp) begin
                errors++;
                $display("FAIL random cyc %0d light %b/%b dir %b/%b hp %b/%b",
                         j, light, e_light, breath_dir, e_dir, half_pulse, e_hp);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        mode_cfg = 8'b01_01_01_01;
        repeat (20 + $urandom_range(0, 20)) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (light !== '0 || breath_dir !== 1'b0 || half_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_reset light %b dir %b hp %b want 0 0 0", light, breath_dir, half_pulse);
        end
        @(posedge system_clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        mode_cfg = 8'($urandom);
        for (int j = 1; j <= 40; j++) begin
            step();
            checks++;
            if (light !== e_light || breath_dir !== e_dir || half_pulse !== e_hp) begin
                errors++;
                $display("FAIL post_reset cyc %0d light %b/%b dir %b/%b hp %b/%b",
                         j, light, e_light, breath_dir, e_dir, half_pulse, e_hp);
            end
        end
    endtask

    // Timing at a second parameter point: half-breath 5*10*10, frame 5*10 cycles.
    task automatic test_scaled();
        int t1 = -1, t2 = -1, r1 = -1, r2 = -1;
        logic prev;
        en = 1'b0;
        step();
        en = 1'b1;
        prev = light_s[0];
        for (int c = 1; c <= 1100; c++) begin
            step();
            if (hp_s) begin
                if (t1 < 0) t1 = c;
                else if (t2 < 0) t2 = c;
            end
            if (t1 > 0 && c > t1 && light_s[0] && !prev) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            prev = light_s[0];
        end
        checks++;
        if (t1 !== 500) begin errors++; $display("FAIL scaled_first_hp got %0d want 500", t1); end
        checks++;
        if (t2 - t1 !== 500) begin errors++; $display("FAIL scaled_hp_spacing got %0d want 500", t2 - t1); end
        checks++;
        if (r1 < 0 || r2 - r1 !== 50) begin errors++; $display("FAIL scaled_frame got %0d want 50", r2 - r1); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_full_breath();
        test_anti();
        test_mode_change();
        test_en_drop();
        test_back_to_back();
        test_async_reset();
        test_scaled();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
